// File: rtl/wishbone_bus_if.sv
// Bridges one SRAM-style core port (rom_* or ram_*) to a Wishbone B4
// classic master; holds the pipeline while a bus cycle is outstanding.
//
// Ports:
//   clk, rst (async, active-low)
//   stall_i, flush_i                      pipeline control from ctrl
//   cpu_ce_i/addr_i/data_i/we_i/sel_i     core request
//   cpu_data_o, stallreq_o                core response (combinational)
//   wb_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o registered Wishbone master
//   wb_dat_i, wb_ack_i                    Wishbone slave response
module wishbone_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat;
  logic                r_we;
  logic [SEL_W-1:0]    r_sel;
  logic                r_cyc;
  logic [DATA_W-1:0]   r_rd_buf;

  logic                w_req;

  assign w_req    = cpu_ce_i && !flush_i;

  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_we_o  = r_we;
  assign wb_sel_o = r_sel;
  // One register drives both: classic single cycles only
  assign wb_stb_o = r_cyc;
  assign wb_cyc_o = r_cyc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_adr    <= '0;
      r_dat    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_cyc    <= 1'b0;
      r_rd_buf <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_adr   <= cpu_addr_i;
            r_dat   <= cpu_data_i;
            r_we    <= cpu_we_i;
            r_sel   <= cpu_sel_i;
            r_cyc   <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            r_adr    <= '0;
            r_dat    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_cyc    <= 1'b0;
            r_rd_buf <= '0;
            r_state  <= IDLE;
          end else if (wb_ack_i) begin
            r_adr    <= '0;
            r_dat    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_cyc    <= 1'b0;
            // a write leaves zero for the core to see while stalled
            r_rd_buf <= r_we ? '0 : wb_dat_i;
            r_state  <= stall_i ? WAIT_STALL : IDLE;
          end
        end
        WAIT_STALL: begin
          if (flush_i) begin
            r_rd_buf <= '0;
            r_state  <= IDLE;
          end else if (!stall_i) begin
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    unique case (r_state)
      IDLE: begin
        stallreq_o = w_req;
      end
      BUSY: begin
        // flush wins over a same-cycle ack
        stallreq_o = !flush_i && !wb_ack_i;
        if (!flush_i && wb_ack_i && !r_we)
          cpu_data_o = wb_dat_i;
      end
      WAIT_STALL: begin
        cpu_data_o = r_rd_buf;
      end
      default: begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if.
// Inputs change after the falling edge; outputs are checked 1ns later.
module tb_wishbone_bus_if;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  int n_err;
  int n_chk;

  wishbone_bus_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, ".cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({tag, ".stb"}, 32'(wb_stb_o), 32'd0);
    chk({tag, ".adr"}, wb_adr_o, 32'd0);
    chk({tag, ".we"},  32'(wb_we_o), 32'd0);
  endtask

  initial begin
    n_err      = 0;
    n_chk      = 0;
    rst        = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    cpu_ce_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    cpu_we_i   = 1'b0;
    cpu_sel_i  = '0;
    wb_dat_i   = '0;
    wb_ack_i   = 1'b0;

    // reset state
    nxt(); settle();
    chk_idle_bus("rst");
    chk("rst.sel", 32'(wb_sel_o), 32'd0);
    chk("rst.data", cpu_data_o, 32'd0);
    chk("rst.stallreq", 32'(stallreq_o), 32'd0);
    nxt(); rst = 1'b1;

    // read, zero wait states
    nxt();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0100; cpu_sel_i = 4'hF;
    settle();
    chk("rd0.req.stallreq", 32'(stallreq_o), 32'd1);
    chk("rd0.req.cyc", 32'(wb_cyc_o), 32'd0);
    nxt();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("rd0.ack.cyc", 32'(wb_cyc_o), 32'd1);
    chk("rd0.ack.stb", 32'(wb_stb_o), 32'd1);
    chk("rd0.ack.adr", wb_adr_o, 32'h0000_0100);
    chk("rd0.ack.we", 32'(wb_we_o), 32'd0);
    chk("rd0.ack.data", cpu_data_o, 32'hDEAD_BEEF);
    chk("rd0.ack.stallreq", 32'(stallreq_o), 32'd0);
    nxt();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    settle();
    chk_idle_bus("rd0.after");
    chk("rd0.after.data", cpu_data_o, 32'd0);
    chk("rd0.after.stallreq", 32'(stallreq_o), 32'd0);

    // write, 3 wait states; cpu_* changes mid-cycle are ignored
    nxt();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1;
    cpu_addr_i = 32'h0000_0200; cpu_data_i = 32'h1234_5678;
    cpu_sel_i = 4'b0011;
    settle();
    chk("wr.req.stallreq", 32'(stallreq_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      cpu_addr_i = 32'hFFFF_0000 + 32'(i);
      cpu_data_i = 32'hCAFE_0000 + 32'(i);
      cpu_sel_i  = 4'b1100;
      cpu_we_i   = 1'b0;
      wb_ack_i   = (i == 3);
      settle();
      chk($sformatf("wr.c%0d.cyc", i), 32'(wb_cyc_o), 32'd1);
      chk($sformatf("wr.c%0d.adr", i), wb_adr_o, 32'h0000_0200);
      chk($sformatf("wr.c%0d.dat", i), wb_dat_o, 32'h1234_5678);
      chk($sformatf("wr.c%0d.sel", i), 32'(wb_sel_o), 32'h3);
      chk($sformatf("wr.c%0d.we", i), 32'(wb_we_o), 32'd1);
      chk($sformatf("wr.c%0d.stallreq", i), 32'(stallreq_o),
          (i == 3) ? 32'd0 : 32'd1);
      chk($sformatf("wr.c%0d.data", i), cpu_data_o, 32'd0);
    end
    nxt();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
    settle();
    chk_idle_bus("wr.after");

    // ack while stalled: data held in WAIT_STALL
    nxt();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0300; stall_i = 1'b1;
    settle();
    chk("ws.req.stallreq", 32'(stallreq_o), 32'd1);
    nxt();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_A5A5;
    settle();
    chk("ws.ack.data", cpu_data_o, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      nxt();
      wb_ack_i = 1'b1; wb_dat_i = 32'h5A5A_0000 + 32'(i);
      settle();
      chk($sformatf("ws.h%0d.data", i), cpu_data_o, 32'hA5A5_A5A5);
      chk($sformatf("ws.h%0d.stallreq", i), 32'(stallreq_o), 32'd0);
      chk($sformatf("ws.h%0d.cyc", i), 32'(wb_cyc_o), 32'd0);
    end
    nxt();
    wb_ack_i = 1'b0; stall_i = 1'b0;
    settle();
    chk("ws.rel.data", cpu_data_o, 32'hA5A5_A5A5);
    nxt();
    settle();
    chk("ws.idle.data", cpu_data_o, 32'd0);
    chk("ws.idle.cyc", 32'(wb_cyc_o), 32'd0);

    // flush in BUSY beats a same-cycle ack
    nxt();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0400;
    settle();
    chk("fl.rdbuf.pre", dut.r_rd_buf, 32'hA5A5_A5A5);
    nxt();
    cpu_ce_i = 1'b0;
    flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    settle();
    chk("fl.cyc", 32'(wb_cyc_o), 32'd1);
    chk("fl.data", cpu_data_o, 32'd0);
    nxt();
    flush_i = 1'b0; wb_ack_i = 1'b0;
    settle();
    chk_idle_bus("fl.after");
    chk("fl.after.data", cpu_data_o, 32'd0);
    chk("fl.after.rdbuf", dut.r_rd_buf, 32'd0);
    chk("fl.after.stallreq", 32'(stallreq_o), 32'd0);

    // flush in IDLE masks a request
    nxt();
    cpu_ce_i = 1'b1; flush_i = 1'b1;
    settle();
    chk("fli.stallreq", 32'(stallreq_o), 32'd0);
    nxt();
    cpu_ce_i = 1'b0; flush_i = 1'b0;
    settle();
    chk("fli.cyc", 32'(wb_cyc_o), 32'd0);

    // async reset mid-transaction
    nxt();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1;
    cpu_addr_i = 32'h0000_0500; cpu_data_i = 32'h0BAD_F00D;
    cpu_sel_i = 4'hF;
    nxt();
    cpu_ce_i = 1'b0;
    settle();
    chk("ar.busy.cyc", 32'(wb_cyc_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk_idle_bus("ar.inrst");
    chk("ar.inrst.dat", wb_dat_o, 32'd0);
    chk("ar.inrst.sel", 32'(wb_sel_o), 32'd0);
    nxt();
    rst = 1'b1;
    nxt();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_0600;
    settle();
    chk("ar.new.cyc0", 32'(wb_cyc_o), 32'd0);
    nxt();
    cpu_ce_i = 1'b0;
    settle();
    chk("ar.new.cyc", 32'(wb_cyc_o), 32'd1);
    chk("ar.new.adr", wb_adr_o, 32'h0000_0600);
    chk("ar.new.we", 32'(wb_we_o), 32'd0);
    chk("ar.new.stallreq", 32'(stallreq_o), 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_8888;
    #1;
    chk("ar.new.data", cpu_data_o, 32'h7777_8888);
    nxt();
    wb_ack_i = 1'b0;
    settle();
    chk("ar.done.cyc", 32'(wb_cyc_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
